// File: rtl/sd_wb_block_dma.sv
// Wishbone B3 classic master moving one 128-word sector between system memory and the
// SD block manager's read/write buffer BRAM ports, one single-beat bus cycle per word.
module sd_wb_block_dma #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 128
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        ext_read_act,
  input  logic [31:0] ext_read_addr,
  input  logic        ext_read_stop,
  output logic        ext_read_go,
  input  logic        ext_write_act,
  input  logic [31:0] ext_write_addr,
  output logic        ext_write_done,
  output logic [6:0]  bram_rd_ext_addr,
  output logic        bram_rd_ext_wren,
  output logic [31:0] bram_rd_ext_data,
  output logic [6:0]  bram_wr_ext_addr,
  input  logic [31:0] bram_wr_ext_q,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err
);

  localparam logic [6:0] LastIdx = 7'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdGo, StRdRel, StWrFetch, StWrReq, StWrDone
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] sector_q, sector_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        wren_q, wren_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        bus_err_q, bus_err_d;
  logic        term;
  logic [31:0] word_adr;

  assign term     = wb_ack_i | wb_err_i;
  // Sector bits above 22 fall off the shift; the sum wraps silently.
  assign word_adr = BASE_ADDR + (sector_q << 9) + {23'b0, idx_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sector_d  = sector_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wren_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (ext_read_act) begin
          sector_d  = ext_read_addr;
          idx_d     = '0;
          bus_err_d = 1'b0;
          state_d   = StRdReq;
        end else if (ext_write_act) begin
          sector_d  = ext_write_addr;
          idx_d     = '0;
          bus_err_d = 1'b0;
          wr_addr_d = '0;
          state_d   = StWrFetch;
        end
      end
      StRdReq: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = word_adr;
        end else if (term) begin
          cyc_d     = 1'b0;
          rd_data_d = wb_dat_i;
          rd_addr_d = idx_q;
          wren_d    = 1'b1;
          if (wb_err_i) bus_err_d = 1'b1;
          if (idx_q == LastIdx) state_d = StRdGo;
          else                  idx_d   = idx_q + 7'd1;
        end
      end
      StRdGo: begin
        if (ext_read_stop) state_d = StRdRel;
      end
      StRdRel: begin
        // Wait for both handshakes to fall so a stale act cannot re-trigger.
        if (!ext_read_act && !ext_read_stop) state_d = StIdle;
      end
      StWrFetch: begin
        state_d = StWrReq;
      end
      StWrReq: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = word_adr;
          dat_d = bram_wr_ext_q;
        end else if (term) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (wb_err_i) bus_err_d = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StWrDone;
          end else begin
            idx_d     = idx_q + 7'd1;
            wr_addr_d = idx_q + 7'd1;
            state_d   = StWrFetch;
          end
        end
      end
      StWrDone: begin
        if (!ext_write_act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      sector_q  <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sector_q  <= sector_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wren_q    <= wren_d;
      wr_addr_q <= wr_addr_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign ext_read_go      = (state_q == StRdGo);
  assign ext_write_done   = (state_q == StWrDone);
  assign bram_rd_ext_addr = rd_addr_q;
  assign bram_rd_ext_wren = wren_q;
  assign bram_rd_ext_data = rd_data_q;
  assign bram_wr_ext_addr = wr_addr_q;
  assign wb_adr_o         = adr_q;
  assign wb_dat_o         = dat_q;
  assign wb_sel_o         = 4'hF;
  assign wb_we_o          = we_q;
  assign wb_cyc_o         = cyc_q;
  assign wb_stb_o         = cyc_q;
  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_sd_wb_block_dma.sv
// Directed bench for sd_wb_block_dma: Wishbone slave with optional wait states and error
// injection, read/write buffer BRAM models, and hand-computed sector addresses and data.
module tb_sd_wb_block_dma;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        ext_read_act, ext_read_stop, ext_read_go;
  logic [31:0] ext_read_addr;
  logic        ext_write_act, ext_write_done;
  logic [31:0] ext_write_addr;
  logic [6:0]  bram_rd_ext_addr, bram_wr_ext_addr;
  logic        bram_rd_ext_wren;
  logic [31:0] bram_rd_ext_data, bram_wr_ext_q;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, bus_err;

  int vectors = 0;
  int miscompares = 0;

  sd_wb_block_dma #(.BASE_ADDR(32'h1000_0000), .WORDS(128)) dut (
    .clk_50(clk_50), .reset_n(reset_n),
    .ext_read_act(ext_read_act), .ext_read_addr(ext_read_addr),
    .ext_read_stop(ext_read_stop), .ext_read_go(ext_read_go),
    .ext_write_act(ext_write_act), .ext_write_addr(ext_write_addr),
    .ext_write_done(ext_write_done),
    .bram_rd_ext_addr(bram_rd_ext_addr), .bram_rd_ext_wren(bram_rd_ext_wren),
    .bram_rd_ext_data(bram_rd_ext_data), .bram_wr_ext_addr(bram_wr_ext_addr),
    .bram_wr_ext_q(bram_wr_ext_q),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_err(bus_err)
  );

  always #10 clk_50 = ~clk_50;

  // Buffer BRAM models; the write buffer has a one-cycle registered read.
  logic [31:0] rdbuf [0:127];
  logic [31:0] wrbuf [0:127];
  int          wren_cnt = 0;
  always @(posedge clk_50) begin
    bram_wr_ext_q <= wrbuf[bram_wr_ext_addr];
    if (bram_rd_ext_wren) begin
      rdbuf[bram_rd_ext_addr] <= bram_rd_ext_data;
      wren_cnt <= wren_cnt + 1;
    end
  end

  // Wishbone slave: read data equals address, writes land in sysmem.
  logic [31:0] sysmem  [0:16383];
  logic [31:0] adr_log [0:2047];
  int          term_cnt = 0;
  int          err_at = -1;
  int          wait_max = 0;
  int          wcnt, wtgt;
  int          gap_err = 0, stab_err = 0, sel_err = 0;
  logic        termd, stb_prev, we_prev;
  logic [31:0] adr_prev, dat_prev;

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= '0;
      wcnt     <= 0;
      wtgt     <= 0;
      termd    <= 1'b0;
      stb_prev <= 1'b0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      termd    <= wb_ack_i | wb_err_i;
      stb_prev <= wb_stb_o;
      adr_prev <= wb_adr_o;
      dat_prev <= wb_dat_o;
      we_prev  <= wb_we_o;
      if (termd && wb_stb_o) gap_err <= gap_err + 1;
      if ((wb_stb_o && !wb_cyc_o) || (wb_stb_o && stb_prev &&
          (wb_adr_o != adr_prev || wb_dat_o != dat_prev || wb_we_o != we_prev)))
        stab_err <= stab_err + 1;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (wcnt >= wtgt || wait_max == 0) begin
          if (term_cnt == err_at) wb_err_i <= 1'b1;
          else                    wb_ack_i <= 1'b1;
          wb_dat_i <= wb_adr_o;
          if (wb_we_o) sysmem[wb_adr_o[15:2]] <= wb_dat_o;
          if (wb_sel_o != 4'hF) sel_err <= sel_err + 1;
          if (term_cnt < 2048) adr_log[term_cnt[10:0]] <= wb_adr_o;
          term_cnt <= term_cnt + 1;
          wcnt     <= 0;
          wtgt     <= int'($urandom_range(wait_max, 0));
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel: 0 = ext_read_go, 1 = ext_write_done, other = wb_stb_o
  task automatic wait_sig(input int sel, input logic lvl, input string tag, output int cyc);
    logic v;
    cyc = 0;
    do begin
      @(negedge clk_50);
      cyc++;
      case (sel)
        0:       v = ext_read_go;
        1:       v = ext_write_done;
        default: v = wb_stb_o;
      endcase
    end while (v !== lvl && cyc < 20000);
    check({tag, " reached"}, 32'(v), 32'(lvl));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " cyc"}, 32'(wb_cyc_o), 32'd0);
    check({tag, " stb"}, 32'(wb_stb_o), 32'd0);
    check({tag, " we"}, 32'(wb_we_o), 32'd0);
    check({tag, " done"}, 32'(ext_write_done), 32'd0);
    check({tag, " go"}, 32'(ext_read_go), 32'd0);
    check({tag, " wren"}, 32'(bram_rd_ext_wren), 32'd0);
    check({tag, " rd_addr"}, 32'(bram_rd_ext_addr), 32'd0);
    check({tag, " wr_addr"}, 32'(bram_wr_ext_addr), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    check({tag, " adr"}, wb_adr_o, 32'd0);
  endtask

  task automatic run_read(input logic [31:0] sector, input logic [31:0] exp0, input int lo,
                          input int hi, input logic exp_err, input string tag);
    int bt, bw, c1, c2;
    bt = term_cnt;
    bw = wren_cnt;
    ext_read_addr = sector;
    ext_read_act  = 1'b1;
    wait_sig(2, 1'b1, {tag, " stb0"}, c1);
    check({tag, " we0"}, 32'(wb_we_o), 32'd0);
    check({tag, " adr0"}, wb_adr_o, exp0);
    wait_sig(0, 1'b1, {tag, " go"}, c2);
    check({tag, " latency"}, 32'(c1 + c2 >= lo && c1 + c2 <= hi), 32'd1);
    check({tag, " bus_err"}, 32'(bus_err), 32'(exp_err));
    repeat (3) @(negedge clk_50);
    check({tag, " go held"}, 32'(ext_read_go), 32'd1);
    check({tag, " words"}, 32'(term_cnt - bt), 32'd128);
    check({tag, " wrens"}, 32'(wren_cnt - bw), 32'd128);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("%s bram[%0d]", tag, i), rdbuf[i], exp0 + 32'(4 * i));
      check($sformatf("%s adr[%0d]", tag, i), adr_log[bt + i], exp0 + 32'(4 * i));
    end
    ext_read_stop = 1'b1;
    @(negedge clk_50);
    check({tag, " go drop"}, 32'(ext_read_go), 32'd0);
    ext_read_act  = 1'b0;
    ext_read_stop = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic run_write(input logic [31:0] sector, input logic [31:0] exp0,
                           input logic [31:0] pat, input string tag);
    int bt, c1, c2;
    bt = term_cnt;
    ext_write_addr = sector;
    ext_write_act  = 1'b1;
    wait_sig(2, 1'b1, {tag, " stb0"}, c1);
    check({tag, " we0"}, 32'(wb_we_o), 32'd1);
    check({tag, " adr0"}, wb_adr_o, exp0);
    check({tag, " dat0"}, wb_dat_o, pat);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    wait_sig(1, 1'b1, {tag, " done"}, c2);
    check({tag, " latency"}, 32'(c1 + c2 >= 510 && c1 + c2 <= 514), 32'd1);
    check({tag, " words"}, 32'(term_cnt - bt), 32'd128);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("%s mem[%0d]", tag, i), sysmem[exp0[15:2] + 14'(i)], pat + 32'(i));
      check($sformatf("%s adr[%0d]", tag, i), adr_log[bt + i], exp0 + 32'(4 * i));
    end
    repeat (3) @(negedge clk_50);
    check({tag, " done held"}, 32'(ext_write_done), 32'd1);
    ext_write_act = 1'b0;
    @(negedge clk_50);
    check({tag, " done drop"}, 32'(ext_write_done), 32'd0);
    @(negedge clk_50);
  endtask

  initial begin
    int bt, n, c;
    reset_n        = 1'b0;
    ext_read_act   = 1'b0;
    ext_read_addr  = '0;
    ext_read_stop  = 1'b0;
    ext_write_act  = 1'b0;
    ext_write_addr = '0;
    for (int i = 0; i < 128; i++) wrbuf[i] = 32'hA500_0000 + 32'(i);

    #35;
    chk_reset("por");
    @(negedge clk_50);
    reset_n = 1'b1;
    @(negedge clk_50);

    run_read(32'd3, 32'h1000_0600, 382, 386, 1'b0, "rd");
    run_write(32'h10, 32'h1000_2000, 32'hA500_0000, "wr");

    wait_max = 5;
    run_read(32'd5, 32'h1000_0A00, 382, 1030, 1'b0, "rdws");
    wait_max = 0;

    // Both requests in the same cycle: read first, write once the read is released.
    for (int i = 0; i < 128; i++) wrbuf[i] = 32'hC300_0000 + 32'(i);
    ext_write_addr = 32'h11;
    ext_write_act  = 1'b1;
    run_read(32'd9, 32'h1000_1200, 382, 386, 1'b0, "both_rd");
    run_write(32'h11, 32'h1000_2200, 32'hC300_0000, "both_wr");

    err_at = term_cnt + 50;
    run_read(32'd7, 32'h1000_0E00, 382, 386, 1'b1, "rderr");
    err_at = -1;

    // Reset while word 64 of a write is on the bus.
    bt = term_cnt;
    ext_write_addr = 32'h30;
    ext_write_act  = 1'b1;
    wait_sig(2, 1'b1, "rst stb0", c);
    check("rst bus_err cleared", 32'(bus_err), 32'd0);
    n = 0;
    while ((term_cnt - bt) < 64 && n < 5000) begin
      @(negedge clk_50);
      n++;
    end
    check("rst reach64", 32'(term_cnt - bt), 32'd64);
    wait_sig(2, 1'b0, "rst gap", c);
    wait_sig(2, 1'b1, "rst stb64", c);
    #2 reset_n = 1'b0;
    #1 chk_reset("rst");
    ext_write_act = 1'b0;
    @(negedge clk_50);
    reset_n = 1'b1;
    @(negedge clk_50);

    for (int i = 0; i < 128; i++) wrbuf[i] = 32'h5A00_0000 + 32'(i);
    run_write(32'h20, 32'h1000_4000, 32'h5A00_0000, "wr2");

    check("gap violations", 32'(gap_err), 32'd0);
    check("stb stability", 32'(stab_err), 32'd0);
    check("sel errors", 32'(sel_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
